// File: rtl/pulse_pkg.sv
// rtl/pulse_pkg.sv - shared types and constants for the pulse conditioning blocks
package pulse_pkg;

  // Threshold / counter width, shared with the pulse extender.
  localparam int THRESH_W = 8;

  // Smallest legal stability threshold; a zero request is raised to this.
  localparam logic [THRESH_W-1:0] THRESH_MIN = 8'd1;

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } deb_state_t;

  // Clamp a requested threshold into 1..255.
  function automatic logic [THRESH_W-1:0] coerce_thresh(input logic [THRESH_W-1:0] value);
    return (value < THRESH_MIN) ? THRESH_MIN : value;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchroniser for a single asynchronous bit
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic in_clock,
  input  logic in_reset_n,
  input  logic in_d,
  output logic out_q
);

  logic [STAGES-1:0] chain;

  // Shift the raw bit through the chain; only the last flop is used downstream.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], in_d};
    end
  end

  assign out_q = chain[STAGES-1];

endmodule

// File: rtl/pulse_debouncer.sv
// rtl/pulse_debouncer.sv - synchronise and debounce a raw pulse into level and edge events
module pulse_debouncer
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DEFAULT_THRESH = 4
) (
  input  logic                in_clock,
  input  logic                in_reset_n,
  input  logic                in_set,
  input  logic [THRESH_W-1:0] in_value,
  output logic                out_ack,
  input  logic                in_raw,
  output logic                out_level,
  output logic                out_pulse,
  output logic                out_fall
);

  logic                s;
  logic [THRESH_W-1:0] thresh;
  logic [THRESH_W-1:0] cnt;
  logic [THRESH_W-1:0] cnt_nxt;
  deb_state_t          state;
  deb_state_t          state_nxt;
  logic                level_nxt;
  logic                pulse_nxt;
  logic                fall_nxt;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync_raw (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .in_d       (in_raw),
    .out_q      (s)
  );

  // Threshold register and its acknowledge; a new value takes effect on the following edge.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      thresh  <= THRESH_W'(DEFAULT_THRESH);
      out_ack <= 1'b0;
    end else begin
      out_ack <= in_set;
      if (in_set) begin
        thresh <= coerce_thresh(in_value);
      end
    end
  end

  // FSM state, stability counter and registered outputs.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state     <= IDLE_LOW;
      cnt       <= '0;
      out_level <= 1'b0;
      out_pulse <= 1'b0;
      out_fall  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_level <= level_nxt;
      out_pulse <= pulse_nxt;
      out_fall  <= fall_nxt;
    end
  end

  // Next state: a level is committed only after thresh+1 consecutive matching samples of s.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = out_level;
    pulse_nxt = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (s) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = THRESH_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_nxt = IDLE_LOW;
          cnt_nxt   = '0;
        end else if (cnt >= thresh) begin
          state_nxt = IDLE_HIGH;
          level_nxt = 1'b1;
          pulse_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + THRESH_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = THRESH_W'(1);
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_nxt = IDLE_HIGH;
          cnt_nxt   = '0;
        end else if (cnt >= thresh) begin
          state_nxt = IDLE_LOW;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + THRESH_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pulse_debouncer.sv
// tb/tb_pulse_debouncer.sv - scoreboard bench for pulse_debouncer
module tb_pulse_debouncer;

  localparam int SYNC = 2;
  localparam int DEF  = 4;

  logic       in_clock;
  logic       in_reset_n;
  logic       in_set;
  logic [7:0] in_value;
  logic       out_ack;
  logic       in_raw;
  logic       out_level;
  logic       out_pulse;
  logic       out_fall;

  typedef struct {
    int kind;   // 0 = rise, 1 = fall
    int at;     // posedge index at which the event is registered
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  edge_n = 0;

  pulse_debouncer #(
    .SYNC_STAGES    (SYNC),
    .DEFAULT_THRESH (DEF)
  ) dut (
    .in_clock   (in_clock),
    .in_reset_n (in_reset_n),
    .in_set     (in_set),
    .in_value   (in_value),
    .out_ack    (out_ack),
    .in_raw     (in_raw),
    .out_level  (out_level),
    .out_pulse  (out_pulse),
    .out_fall   (out_fall)
  );

  initial in_clock = 1'b0;
  always #5 in_clock = ~in_clock;

  always @(posedge in_clock) edge_n++;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Every rise/fall pulse seen must match the oldest expected event.
  always @(negedge in_clock) begin
    if (in_reset_n && (out_pulse || out_fall)) begin
      check("pulse_fall_exclusive", int'(out_pulse && out_fall), 0);
      if (q.size() == 0) begin
        check("unexpected_event_at", edge_n, -1);
      end else begin
        ev_t e;
        e = q.pop_front();
        check("event_kind", out_fall ? 1 : 0, e.kind);
        check("event_edge", edge_n, e.at);
        check("event_level", int'(out_level), (e.kind == 0) ? 1 : 0);
      end
    end
  end

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge in_clock);
      n++;
    end
    check("drain_pending", q.size(), 0);
    q.delete();
  endtask

  task automatic set_thresh(input int v);
    in_set   = 1'b1;
    in_value = 8'(v);
    @(negedge in_clock);
    check("ack_high", int'(out_ack), 1);
    in_set = 1'b0;
    @(negedge in_clock);
    check("ack_low", int'(out_ack), 0);
  endtask

  // Raw high pulse of 'width' cycles; accepted only if width >= th+1.
  task automatic raw_pulse(input int width, input int th);
    int k;
    k = edge_n + 1;
    in_raw = 1'b1;
    if (width >= th + 1) begin
      push_ev(0, k + SYNC + th);
      push_ev(1, k + width + SYNC + th);
    end
    repeat (width) @(negedge in_clock);
    in_raw = 1'b0;
    drain(2 * th + width + 20);
    repeat (th + SYNC + 4) @(negedge in_clock);
  endtask

  initial begin
    int k;
    in_reset_n = 1'b0;
    in_raw     = 1'b0;
    in_set     = 1'b0;
    in_value   = 8'd0;
    #1;
    check("rst_level", int'(out_level), 0);
    check("rst_pulse", int'(out_pulse), 0);
    check("rst_fall",  int'(out_fall),  0);
    check("rst_ack",   int'(out_ack),   0);
    repeat (3) @(negedge in_clock);
    in_reset_n = 1'b1;
    @(negedge in_clock);

    // Defaults: 4 cycles rejected, 5 cycles accepted.
    raw_pulse(4, DEF);
    check("short_level_low", int'(out_level), 0);
    raw_pulse(5, DEF);

    // Zero threshold coerced to 1.
    set_thresh(0);
    raw_pulse(1, 1);
    raw_pulse(2, 1);

    // in_set held three cycles: ack high throughout, last value wins.
    in_set = 1'b1; in_value = 8'd7;
    @(negedge in_clock);
    check("ack_hold_1", int'(out_ack), 1);
    in_value = 8'd9;
    @(negedge in_clock);
    check("ack_hold_2", int'(out_ack), 1);
    in_value = 8'd3;
    @(negedge in_clock);
    check("ack_hold_3", int'(out_ack), 1);
    in_set = 1'b0;
    @(negedge in_clock);
    check("ack_hold_end", int'(out_ack), 0);
    raw_pulse(3, 3);
    raw_pulse(4, 3);

    // Glitch train with threshold 4: nothing may commit.
    set_thresh(4);
    for (int i = 0; i < 50; i++) begin
      in_raw = (i % 2 == 0);
      @(negedge in_clock);
    end
    in_raw = 1'b0;
    repeat (12) @(negedge in_clock);
    check("glitch_level_low", int'(out_level), 0);

    // Threshold lowered from 10 to 2 while counting with cnt=3.
    set_thresh(10);
    k = edge_n + 1;
    in_raw = 1'b1;
    push_ev(0, k + 6);
    repeat (5) @(negedge in_clock);
    in_set = 1'b1; in_value = 8'd2;
    @(negedge in_clock);
    in_set = 1'b0;
    repeat (10) @(negedge in_clock);
    in_raw = 1'b0;
    push_ev(1, edge_n + 1 + SYNC + 2);
    drain(40);
    repeat (8) @(negedge in_clock);

    // Largest threshold.
    set_thresh(255);
    raw_pulse(255, 255);
    raw_pulse(256, 255);

    // Reset during WAIT_LOW discards the pending fall.
    set_thresh(4);
    k = edge_n + 1;
    in_raw = 1'b1;
    push_ev(0, k + SYNC + 4);
    drain(30);
    repeat (4) @(negedge in_clock);
    in_raw = 1'b0;
    repeat (4) @(negedge in_clock);
    #2;
    in_reset_n = 1'b0;
    in_raw     = 1'b1;
    #1;
    check("midreset_level", int'(out_level), 0);
    check("midreset_pulse", int'(out_pulse), 0);
    check("midreset_fall",  int'(out_fall),  0);
    check("midreset_ack",   int'(out_ack),   0);
    repeat (2) @(negedge in_clock);
    in_reset_n = 1'b1;
    k = edge_n + 1;
    push_ev(0, k + SYNC + DEF);
    drain(30);
    repeat (3) @(negedge in_clock);
    in_raw = 1'b0;
    push_ev(1, edge_n + 1 + SYNC + DEF);
    drain(30);
    repeat (10) @(negedge in_clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
